// File: rtl/rv32_pipe_pkg.sv
// Shared opcode constants, forwarding-select encoding and the per-stage shadow slot
// used by the RV32I hazard/forwarding controller.
package rv32_pipe_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              regwrite;
    logic              is_load;
    logic              uses_rs1;
    logic              uses_rs2;
  } slot_t;

endpackage

// File: rtl/rv_instr_class.sv
// Combinational classifier: turns an RV32I instruction word into the register-usage
// shadow carried alongside it through the pipeline.
module rv_instr_class
  import rv32_pipe_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               valid,
  output slot_t              slot
);

  logic unused_bits;
  assign unused_bits = ^{instr[INSTR_W-1:25], instr[14:12]};

  always_comb begin
    slot          = '0;
    slot.valid    = valid;
    slot.rd       = instr[11:7];
    slot.rs1      = instr[19:15];
    slot.rs2      = instr[24:20];
    // Unknown opcodes fall through with every usage flag clear.
    case (instr[6:0])
      LOAD:   begin slot.regwrite = 1'b1; slot.uses_rs1 = 1'b1; slot.is_load = 1'b1; end
      STORE:  begin slot.uses_rs1 = 1'b1; slot.uses_rs2 = 1'b1; end
      OP:     begin slot.regwrite = 1'b1; slot.uses_rs1 = 1'b1; slot.uses_rs2 = 1'b1; end
      OP_IMM: begin slot.regwrite = 1'b1; slot.uses_rs1 = 1'b1; end
      BRANCH: begin slot.uses_rs1 = 1'b1; slot.uses_rs2 = 1'b1; end
      JAL:    slot.regwrite = 1'b1;
      JALR:   begin slot.regwrite = 1'b1; slot.uses_rs1 = 1'b1; end
      LUI:    slot.regwrite = 1'b1;
      AUIPC:  slot.regwrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I core: shadows rd/rs per stage,
// raises load-use stalls, flush bubbles, operand forwarding selects and the WB write port.
module hazard_fwd_unit
  import rv32_pipe_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int RADDR_W = 5,
  parameter int PERF_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               id_valid,
  input  logic               ex_flush,
  input  logic               mem_stall,
  output logic               stall_if,
  output logic               stall_id,
  output logic               bubble_ex,
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [PERF_W-1:0]  stall_count
);

  slot_t id_p0, ex_p1, mem_p2, wb_p3;
  logic  load_use;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic writes_reg(input slot_t s, input logic [REG_AW-1:0] rs);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == rs);
  endfunction

  function automatic fwd_sel_e fwd_pick(input logic used, input logic [REG_AW-1:0] rs,
                                        input slot_t mem, input slot_t wb);
    if (!used)                 return FWD_RF;
    else if (writes_reg(mem, rs)) return FWD_MEM;
    else if (writes_reg(wb, rs))  return FWD_WB;
    else                       return FWD_RF;
  endfunction

  rv_instr_class #(.INSTR_W(INSTR_W)) u_cls (
    .instr (id_instr),
    .valid (id_valid),
    .slot  (id_p0)
  );

  // ID stage: hazard against the load sitting in EX
  assign load_use = ex_p1.valid && ex_p1.is_load && (ex_p1.rd != '0) &&
                    ((id_p0.uses_rs1 && (id_p0.rs1 == ex_p1.rd)) ||
                     (id_p0.uses_rs2 && (id_p0.rs2 == ex_p1.rd)));

  // A pending memory freeze overrides both flush and load-use for this cycle.
  assign stall_if  = mem_stall || (load_use && !ex_flush);
  assign stall_id  = stall_if;
  assign bubble_ex = !mem_stall && (ex_flush || load_use);

  // EX stage: operand forwarding from MEM/WB shadows
  assign fwd_a_sel = fwd_pick(ex_p1.valid && ex_p1.uses_rs1, ex_p1.rs1, mem_p2, wb_p3);
  assign fwd_b_sel = fwd_pick(ex_p1.valid && ex_p1.uses_rs2, ex_p1.rs2, mem_p2, wb_p3);

  // WB stage: register file write port
  assign wb_we = wb_p3.valid && wb_p3.regwrite && (wb_p3.rd != '0);
  assign wb_rd = wb_we ? RADDR_W'(wb_p3.rd) : '0;

  logic unused_fields;
  assign unused_fields = ^{ex_p1.regwrite,
                           mem_p2.rs1, mem_p2.rs2, mem_p2.is_load, mem_p2.uses_rs1, mem_p2.uses_rs2,
                           wb_p3.rs1, wb_p3.rs2, wb_p3.is_load, wb_p3.uses_rs1, wb_p3.uses_rs2};

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_p1.valid  <= 1'b0;
      mem_p2.valid <= 1'b0;
      wb_p3.valid  <= 1'b0;
      stall_count  <= '0;
    end else if (!mem_stall) begin
      wb_p3  <= mem_p2;
      mem_p2 <= ex_p1;
      if (ex_flush || load_use) ex_p1.valid <= 1'b0;
      else                      ex_p1       <= id_p0;
      if (load_use && !ex_flush) stall_count <= sat_inc(stall_count);
    end
  end

endmodule
